// File: rtl/calculadora_sincrona_multi.sv
// calculadora_sincrona_multi
//   Accumulator calculator with NUM_ACC independent WIDTH-bit accumulators,
//   a valid/ready command port, status flags, bitwise ops and an iterative
//   shift-add multiply (WIDTH cycles).
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   command handshake; in_ready = ~busy
//   entrada, codigo,    operand, opcode, target accumulator index
//   acc_sel
//   saida, out_valid    registered display value and its one-cycle update pulse
//   busy                multiply in progress
//   flag_zero/carry/ovf status of the last arithmetic/logic result
//   err                 one-cycle pulse on an accepted invalid opcode

// One accumulator register; written only when its index is selected.
module calc_acc_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module calculadora_sincrona_multi #(
  parameter int WIDTH   = 8,
  parameter int NUM_ACC = 4,
  parameter int SEL_W   = $clog2(NUM_ACC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] entrada,
  input  logic [2:0]       codigo,
  input  logic [SEL_W-1:0] acc_sel,
  output logic [WIDTH-1:0] saida,
  output logic             out_valid,
  output logic             busy,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             err
);
  localparam logic [2:0] OP_SHOW_IN  = 3'b000;
  localparam logic [2:0] OP_ADD      = 3'b001;
  localparam logic [2:0] OP_SUB      = 3'b010;
  localparam logic [2:0] OP_SHOW_ACC = 3'b011;
  localparam logic [2:0] OP_AND      = 3'b100;
  localparam logic [2:0] OP_XOR      = 3'b101;
  localparam logic [2:0] OP_MUL      = 3'b110;
  localparam int         CNT_W       = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t                          state;
  logic [NUM_ACC-1:0][WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]                a_val;
  logic                            accept;

  // Multiply datapath
  logic [2*WIDTH-1:0]              prod, mcand, prod_step;
  logic [WIDTH-1:0]                mplier;
  logic [CNT_W-1:0]                count;
  logic [SEL_W-1:0]                tgt;
  logic                            mul_done;

  // Single-cycle ALU
  logic [WIDTH:0]                  sum_w, diff_w;
  logic [WIDTH-1:0]                alu_res;
  logic                            alu_wr, c_n, v_n, z_n;

  // Accumulator write port (one writer per cycle)
  logic                            wr_en;
  logic [SEL_W-1:0]                wr_idx;
  logic [WIDTH-1:0]                wr_data;

  assign in_ready = ~busy;
  assign accept   = in_valid & in_ready;
  assign a_val    = acc_q[acc_sel];

  assign sum_w  = {1'b0, a_val} + {1'b0, entrada};
  // Top bit of the extended difference is the unsigned borrow.
  assign diff_w = {1'b0, a_val} - {1'b0, entrada};

  always_comb begin
    alu_res = '0;
    c_n     = 1'b0;
    v_n     = 1'b0;
    alu_wr  = 1'b0;
    case (codigo)
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        c_n     = sum_w[WIDTH];
        v_n     = (a_val[WIDTH-1] == entrada[WIDTH-1]) &&
                  (sum_w[WIDTH-1] != a_val[WIDTH-1]);
        alu_wr  = 1'b1;
      end
      OP_SUB: begin
        alu_res = diff_w[WIDTH-1:0];
        c_n     = diff_w[WIDTH];
        v_n     = (a_val[WIDTH-1] != entrada[WIDTH-1]) &&
                  (diff_w[WIDTH-1] != a_val[WIDTH-1]);
        alu_wr  = 1'b1;
      end
      OP_AND: begin
        alu_res = a_val & entrada;
        alu_wr  = 1'b1;
      end
      OP_XOR: begin
        alu_res = a_val ^ entrada;
        alu_wr  = 1'b1;
      end
      default: ;
    endcase
  end

  assign z_n = (alu_res == '0);

  // The final shift-add step and the write-back share an edge, so the
  // result is taken from the combinational next product.
  assign prod_step = prod + (mplier[0] ? mcand : '0);
  assign mul_done  = (state == MUL) && (count == CNT_W'(1));

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = acc_sel;
    wr_data = alu_res;
    if (accept && alu_wr) begin
      wr_en = 1'b1;
    end else if (mul_done) begin
      wr_en   = 1'b1;
      wr_idx  = tgt;
      wr_data = prod_step[WIDTH-1:0];
    end
  end

  for (genvar i = 0; i < NUM_ACC; i++) begin : g_acc
    calc_acc_slot #(.WIDTH(WIDTH)) u_slot (
      .clk (clk),
      .rst (rst),
      .we  (wr_en && (wr_idx == SEL_W'(i))),
      .d   (wr_data),
      .q   (acc_q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      saida      <= '0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      prod       <= '0;
      mcand      <= '0;
      mplier     <= '0;
      count      <= '0;
      tgt        <= '0;
    end else begin
      out_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (codigo)
              OP_SHOW_IN: begin
                saida     <= entrada;
                out_valid <= 1'b1;
              end
              OP_SHOW_ACC: begin
                saida     <= a_val;
                out_valid <= 1'b1;
              end
              OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
                flag_zero  <= z_n;
                flag_carry <= c_n;
                flag_ovf   <= v_n;
              end
              OP_MUL: begin
                mcand  <= {{WIDTH{1'b0}}, a_val};
                mplier <= entrada;
                tgt    <= acc_sel;
                prod   <= '0;
                count  <= CNT_W'(WIDTH);
                busy   <= 1'b1;
                state  <= MUL;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        MUL: begin
          prod   <= prod_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CNT_W'(1);
          if (mul_done) begin
            saida      <= prod_step[WIDTH-1:0];
            out_valid  <= 1'b1;
            flag_carry <= (prod_step[2*WIDTH-1:WIDTH] != '0);
            flag_ovf   <= 1'b0;
            flag_zero  <= (prod_step[WIDTH-1:0] == '0);
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calculadora_sincrona_multi.sv
module tb_calculadora_sincrona_multi;
  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // WIDTH=8, NUM_ACC=4 instance
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  entrada = '0;
  logic [2:0]  codigo = '0;
  logic [1:0]  acc_sel = '0;
  logic [7:0]  saida;
  logic        out_valid, busy, flag_zero, flag_carry, flag_ovf, err;

  // WIDTH=16, NUM_ACC=8 instance
  logic        w_in_valid = 1'b0, w_in_ready;
  logic [15:0] w_entrada = '0;
  logic [2:0]  w_codigo = '0;
  logic [2:0]  w_acc_sel = '0;
  logic [15:0] w_saida;
  logic        w_out_valid, w_busy, w_zero, w_carry, w_ovf, w_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calculadora_sincrona_multi #(.WIDTH(8), .NUM_ACC(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .entrada(entrada), .codigo(codigo), .acc_sel(acc_sel), .saida(saida),
    .out_valid(out_valid), .busy(busy), .flag_zero(flag_zero),
    .flag_carry(flag_carry), .flag_ovf(flag_ovf), .err(err)
  );

  calculadora_sincrona_multi #(.WIDTH(16), .NUM_ACC(8)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .entrada(w_entrada), .codigo(w_codigo), .acc_sel(w_acc_sel), .saida(w_saida),
    .out_valid(w_out_valid), .busy(w_busy), .flag_zero(w_zero),
    .flag_carry(w_carry), .flag_ovf(w_ovf), .err(w_err)
  );

  // Present one command for one cycle; returns 1 time unit after the accept edge.
  task automatic cmd(input logic [2:0] op, input logic [1:0] sel, input logic [7:0] e);
    @(negedge clk);
    in_valid = 1'b1; codigo = op; acc_sel = sel; entrada = e;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wcmd(input logic [2:0] op, input logic [2:0] sel, input logic [15:0] e);
    @(negedge clk);
    w_in_valid = 1'b1; w_codigo = op; w_acc_sel = sel; w_entrada = e;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_busy busy=%b ready=%b exp 0/1", busy, in_ready); end
    checks++; if ({saida, out_valid, err} !== 10'h0) begin errors++; $display("FAIL reset_out saida=%0h ov=%b err=%b exp 0", saida, out_valid, err); end
    checks++; if ({flag_zero, flag_carry, flag_ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {flag_zero, flag_carry, flag_ovf}); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd(3'b011, 2'(i), 8'h00);
      checks++; if (saida !== 8'h00 || out_valid !== 1'b1) begin errors++; $display("FAIL reset_show%0d saida=%0h ov=%b exp 0/1", i, saida, out_valid); end
    end
    checks++; if ({flag_zero, flag_carry, flag_ovf} !== 3'b000) begin errors++; $display("FAIL reset_show_flags got %b exp 000", {flag_zero, flag_carry, flag_ovf}); end
  endtask

  task automatic test_reset_mid_mul;
    cmd(3'b001, 2'd0, 8'd9);
    cmd(3'b110, 2'd0, 8'd7);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midmul_rst busy=%b ready=%b exp 0/1", busy, in_ready); end
    @(negedge clk); rst = 1'b0;
    cmd(3'b011, 2'd0, 8'h00);
    checks++; if (saida !== 8'h00 || out_valid !== 1'b1) begin errors++; $display("FAIL midmul_acc0 saida=%0h ov=%b exp 0/1", saida, out_valid); end
  endtask

  task automatic test_add_sub;
    cmd(3'b001, 2'd0, 8'd200);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_no_ov got %b exp 0", out_valid); end
    cmd(3'b001, 2'd0, 8'd100);
    checks++; if ({flag_zero, flag_carry, flag_ovf} !== 3'b010) begin errors++; $display("FAIL add_wrap_flags got %b exp 010", {flag_zero, flag_carry, flag_ovf}); end
    cmd(3'b011, 2'd0, 8'h00);
    checks++; if (saida !== 8'd44) begin errors++; $display("FAIL add_wrap_val got %0d exp 44", saida); end
    cmd(3'b001, 2'd1, 8'd127);
    cmd(3'b001, 2'd1, 8'd1);
    checks++; if ({flag_zero, flag_carry, flag_ovf} !== 3'b001) begin errors++; $display("FAIL add_ovf_flags got %b exp 001", {flag_zero, flag_carry, flag_ovf}); end
    cmd(3'b011, 2'd1, 8'h00);
    checks++; if (saida !== 8'd128) begin errors++; $display("FAIL add_ovf_val got %0d exp 128", saida); end
    cmd(3'b010, 2'd2, 8'd1);
    checks++; if ({flag_zero, flag_carry, flag_ovf} !== 3'b010) begin errors++; $display("FAIL sub_borrow_flags got %b exp 010", {flag_zero, flag_carry, flag_ovf}); end
    cmd(3'b011, 2'd2, 8'h00);
    checks++; if (saida !== 8'd255) begin errors++; $display("FAIL sub_borrow_val got %0d exp 255", saida); end
    cmd(3'b010, 2'd2, 8'd255);
    checks++; if ({flag_zero, flag_carry, flag_ovf} !== 3'b100) begin errors++; $display("FAIL sub_zero_flags got %b exp 100", {flag_zero, flag_carry, flag_ovf}); end
  endtask

  task automatic test_mul;
    int n;
    cmd(3'b001, 2'd2, 8'd13);
    cmd(3'b110, 2'd2, 8'd11);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_ready_low cyc %0d got %b exp 0", n, in_ready); end
      @(posedge clk); #1;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL mul_busy_cycles got %0d exp 8", n); end
    checks++; if (saida !== 8'd143 || out_valid !== 1'b1) begin errors++; $display("FAIL mul_result saida=%0d ov=%b exp 143/1", saida, out_valid); end
    checks++; if ({flag_zero, flag_carry, flag_ovf} !== 3'b000) begin errors++; $display("FAIL mul_flags got %b exp 000", {flag_zero, flag_carry, flag_ovf}); end
  endtask

  task automatic test_mul_hold;
    int n;
    logic early;
    cmd(3'b010, 2'd2, 8'd123);
    cmd(3'b110, 2'd2, 8'd20);
    @(negedge clk);
    in_valid = 1'b1; codigo = 3'b000; acc_sel = 2'd0; entrada = 8'h55;
    n = 0; early = 1'b0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(posedge clk); #1;
      if (busy === 1'b1 && out_valid !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL hold_accepted_while_busy got %b exp 0", early); end
    checks++; if (n !== 8) begin errors++; $display("FAIL hold_busy_cycles got %0d exp 8", n); end
    checks++; if (saida !== 8'd144 || out_valid !== 1'b1 || flag_carry !== 1'b1) begin errors++; $display("FAIL mul_ovf saida=%0d ov=%b c=%b exp 144/1/1", saida, out_valid, flag_carry); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (saida !== 8'h55 || out_valid !== 1'b1) begin errors++; $display("FAIL hold_after_busy saida=%0h ov=%b exp 55/1", saida, out_valid); end
  endtask

  task automatic test_invalid;
    cmd(3'b111, 2'd1, 8'h12);
    checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL invalid_err err=%b ov=%b exp 1/0", err, out_valid); end
    checks++; if (saida !== 8'h55 || {flag_zero, flag_carry, flag_ovf} !== 3'b010) begin errors++; $display("FAIL invalid_state saida=%0h flags=%b exp 55/010", saida, {flag_zero, flag_carry, flag_ovf}); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL invalid_pulse got %b exp 0", err); end
  endtask

  task automatic test_logic;
    cmd(3'b001, 2'd3, 8'hF0);
    cmd(3'b100, 2'd3, 8'h3C);
    cmd(3'b011, 2'd3, 8'h00);
    checks++; if (saida !== 8'h30) begin errors++; $display("FAIL and_val got %0h exp 30", saida); end
    cmd(3'b101, 2'd3, 8'h30);
    checks++; if ({flag_zero, flag_carry, flag_ovf} !== 3'b100) begin errors++; $display("FAIL xor_flags got %b exp 100", {flag_zero, flag_carry, flag_ovf}); end
    cmd(3'b011, 2'd0, 8'h00);
    checks++; if (saida !== 8'd44) begin errors++; $display("FAIL keep_acc0 got %0d exp 44", saida); end
    cmd(3'b011, 2'd1, 8'h00);
    checks++; if (saida !== 8'd128) begin errors++; $display("FAIL keep_acc1 got %0d exp 128", saida); end
    cmd(3'b011, 2'd2, 8'h00);
    checks++; if (saida !== 8'd144) begin errors++; $display("FAIL keep_acc2 got %0d exp 144", saida); end
    cmd(3'b011, 2'd3, 8'h00);
    checks++; if (saida !== 8'h00) begin errors++; $display("FAIL xor_val got %0h exp 0", saida); end
  endtask

  task automatic test_wide;
    int n;
    wcmd(3'b001, 3'd5, 16'hFFFF);
    wcmd(3'b001, 3'd5, 16'h0001);
    checks++; if ({w_zero, w_carry, w_ovf} !== 3'b110) begin errors++; $display("FAIL w_add_flags got %b exp 110", {w_zero, w_carry, w_ovf}); end
    wcmd(3'b011, 3'd5, 16'h0000);
    checks++; if (w_saida !== 16'h0000 || w_out_valid !== 1'b1) begin errors++; $display("FAIL w_add_val saida=%0h ov=%b exp 0/1", w_saida, w_out_valid); end
    wcmd(3'b001, 3'd6, 16'd300);
    wcmd(3'b110, 3'd6, 16'd300);
    n = 0;
    while (w_busy === 1'b1 && n < 80) begin
      n++;
      @(posedge clk); #1;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL w_mul_cycles got %0d exp 16", n); end
    checks++; if (w_saida !== 16'h5F90 || w_out_valid !== 1'b1 || w_carry !== 1'b1) begin errors++; $display("FAIL w_mul saida=%0h ov=%b c=%b exp 5f90/1/1", w_saida, w_out_valid, w_carry); end
    wcmd(3'b011, 3'd7, 16'h0000);
    checks++; if (w_saida !== 16'h0000) begin errors++; $display("FAIL w_keep_acc7 got %0h exp 0", w_saida); end
  endtask

  initial begin
    test_reset;
    test_reset_mid_mul;
    test_add_sub;
    test_mul;
    test_mul_hold;
    test_invalid;
    test_logic;
    test_wide;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/calculadora_sincrona_multi.md
Name: calculadora_sincrona_multi

Overview:
Parametrised accumulator calculator and the next generation of the team's 8-bit synchronous calculator. It provides NUM_ACC independent accumulators of WIDTH bits and a valid/ready command interface. It adds status flags, bitwise ops and a multi-cycle iterative multiply. It sits between the switch/keypad input logic and the display driver, one command per accepted handshake.

Parameters:
WIDTH, 8, data/accumulator width in bits (>=2)
NUM_ACC, 4, number of accumulators (power of 2, >=2)
SEL_W, $clog2(NUM_ACC), width of acc_sel (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  command present on entrada/codigo/acc_sel
in_ready  output  1  block can accept a command (= ~busy, combinational from state)
entrada  input  WIDTH  operand
codigo  input  3  opcode
acc_sel  input  SEL_W  target accumulator index
saida  output  WIDTH  registered result/display value
out_valid  output  1  one-cycle pulse: saida updated this cycle
busy  output  1  multiply in progress
flag_zero  output  1  last arithmetic/logic result == 0
flag_carry  output  1  carry/borrow/mul-overflow of last arithmetic op
flag_ovf  output  1  signed overflow of last add/sub
err  output  1  one-cycle pulse: accepted invalid opcode

Behaviour:
- Reset (async, any state incl. mid-multiply): all accumulators, saida, flags = 0; out_valid = 0; err = 0; busy = 0; FSM to IDLE; any multiply is discarded.
- Accept = in_valid && in_ready at rising edge. Without accept: no state change, out_valid = 0, err = 0. Source must hold the command while in_ready = 0.
- A = acc[acc_sel], E = entrada, both sampled at the accept edge. All single-cycle ops update registers at the accept edge, so results are visible the following cycle.
- 000 SHOW_IN: saida <= E; out_valid pulses.
- 001 ADD: A <= (A+E) mod 2^WIDTH; carry = bit WIDTH of unsigned sum; ovf = signed overflow (operand signs equal, result sign differs); zero from result. saida unchanged, no out_valid.
- 010 SUB: A <= (A-E) mod 2^WIDTH; carry = borrow (1 when A<E unsigned); ovf = signed overflow (operand signs differ, result sign differs from A); zero from result. saida unchanged.
- 011 SHOW_ACC: saida <= A; out_valid pulses; flags unchanged.
- 100 AND: A <= A & E; zero updated; carry = ovf = 0.
- 101 XOR: A <= A ^ E; zero updated; carry = ovf = 0.
- 110 MUL: multi-cycle; see FSM below.
- 111 invalid: err pulses for one cycle; accumulators, saida and flags unchanged.
- FSM states:
  - IDLE -> MUL on an accepted 110. Capture multiplicand = A, multiplier = E, target index = acc_sel; clear the 2*WIDTH-bit product register; set count = WIDTH.
  - MUL: one shift-add step per cycle, LSB of multiplier first. busy = 1 and in_ready = 0 for exactly WIDTH cycles after the accept edge.
  - On the WIDTH-th edge after accept: target acc <= low WIDTH bits of the unsigned product; saida <= same value; out_valid pulses; carry = (high WIDTH bits != 0); ovf = 0; zero from the low bits. FSM -> IDLE, so busy = 0 and in_ready = 1 in the following cycle.
- Only the selected accumulator changes; all others hold.
- Wrap-around is modulo 2^WIDTH with no saturation.
- Back-to-back commands accepted every cycle except during MUL.
- Same-index read-after-write on consecutive cycles sees the updated value (no hazard, registered state).

Test Plan:
- Reset then SHOW_ACC on each index -> saida = 0, out_valid pulse, all flags 0; assert rst mid-MUL -> busy = 0 immediately, acc unchanged = 0.
- WIDTH=8: ADD 200 to acc0, then ADD 100 -> acc0 = 44, carry = 1; SHOW_ACC -> saida = 44.
- acc1 ADD 127 then ADD 1 -> acc1 = 128, ovf = 1, carry = 0. SUB from 0 by 1 -> 255, carry (borrow) = 1. SUB equal values -> zero = 1.
- acc2 = 13, MUL by 11 -> in_ready low 8 cycles, then saida = 143, out_valid pulse, carry = 0. acc2 = 20, MUL by 20 -> 144, carry = 1. in_valid held during busy -> not accepted until in_ready returns.
- codigo 111 -> err pulse, no register changes. AND/XOR on acc3 (0xF0 & 0x3C = 0x30, then ^0x30 = 0, zero = 1); other accumulators unchanged.
- Param sweep WIDTH=16, NUM_ACC=8: 0xFFFF+1 -> 0 with carry = 1; MUL 300*300 -> 0x5F90 with carry = 1.
